// File: rtl/multiword_add_seq.sv
// Streams two multi-precision operands LSW first through a 32-bit ripple-carry adder, chaining the carry between words.
// Optional subtract mode (A-B) is enabled by defining MULTIWORD_ADD_SUB_EN.

module multiword_add_rca #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          p_in,
  output logic [DW-1:0] s,
  output logic          p_out
);

  logic carry;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    s     = '0;
    carry = p_in;
    for (int i = 0; i < DW; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    p_out = carry;
  end

endmodule

module multiword_add_seq #(
  parameter int LEN_W = 4,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             cin,
`ifdef MULTIWORD_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_sum,
  output logic             out_last,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_sum_q, out_sum_d;
  logic             out_last_q, out_last_d;
  logic             carry_out_q, carry_out_d;
  logic             done_q, done_d;
`ifdef MULTIWORD_ADD_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic             start_ok;
  logic             in_fire;
  logic             out_fire;
  logic             last_word;
  logic [DW-1:0]    b_eff;
  logic             init_carry;
  logic [DW-1:0]    add_s;
  logic             add_c;

  assign start_ok  = (state_q == IDLE) && start && (len != '0);
  assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
  assign in_fire   = in_ready && in_valid;
  assign out_fire  = out_valid_q && out_ready;
  assign last_word = (cnt_q == LEN_W'(1));

`ifdef MULTIWORD_ADD_SUB_EN
  assign b_eff      = sub_q ? ~in_b : in_b;
  assign init_carry = sub ? 1'b1 : cin;
`else
  assign b_eff      = in_b;
  assign init_carry = cin;
`endif

  multiword_add_rca #(.DW(DW)) u_rca (
    .a    (in_a),
    .b    (b_eff),
    .p_in (carry_q),
    .s    (add_s),
    .p_out(add_c)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      carry_out_q <= carry_out_d;
      done_q      <= done_d;
`ifdef MULTIWORD_ADD_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (in_fire && last_word) state_d = DRAIN;
      DRAIN:   if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    carry_out_d = carry_out_q;
    done_d      = 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
    sub_d       = sub_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          cnt_d       = len;
          carry_d     = init_carry;
          carry_out_d = 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
          sub_d       = sub;
`endif
        end
      end
      RUN: begin
        // Output register drains and refills in the same cycle when the consumer is ready.
        if (in_fire) begin
          out_sum_d   = add_s;
          carry_d     = add_c;
          out_valid_d = 1'b1;
          out_last_d  = last_word;
          cnt_d       = cnt_q - LEN_W'(1);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          carry_out_d = carry_q;
          done_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign carry_out = carry_out_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: directed cases plus randomized operations against a wide-integer model.
// Exercises subtract mode too when MULTIWORD_ADD_SUB_EN is defined.

module tb_multiword_add_seq;

  localparam int LEN_W  = 4;
  localparam int DW     = 32;
  localparam int BUDGET = 2000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             cin;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_sum;
  logic             out_last;
  logic             carry_out;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] a_w   [16];
  logic [DW-1:0] b_w   [16];
  logic [DW-1:0] exp_w [16];
  logic          exp_c;

  multiword_add_seq #(.LEN_W(LEN_W), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .cin      (cin),
`ifdef MULTIWORD_ADD_SUB_EN
    .sub      (sub),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_last (out_last),
    .carry_out(carry_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: treat the operands as one wide integer and add them in a single step.
  task automatic model(input int n, input logic c0, input logic s);
    logic [511:0] a_big, b_big, sum_big;
    a_big = '0;
    b_big = '0;
    for (int i = 0; i < n; i++) begin
      a_big[32*i +: 32] = a_w[i];
      b_big[32*i +: 32] = s ? ~b_w[i] : b_w[i];
    end
    sum_big = a_big + b_big + 512'(s ? 1'b1 : c0);
    for (int i = 0; i < n; i++) exp_w[i] = sum_big[32*i +: 32];
    exp_c = sum_big[32*n];
  endtask

  task automatic run_op(input int n, input logic c0, input logic s, input int in_pct,
                        input int out_pct, input int stall_n, input bit mid_start);
    int   wi, oi, cyc, stall_left;
    bit   seen_first, in_fire, out_fire;
    model(n, c0, s);
    start = 1'b1; len = LEN_W'(n); cin = c0; sub = s;
    @(posedge clk); #1;
    start = 1'b0; len = '0; cin = 1'b0; sub = 1'b0;
    check("busy_after_start", busy, 1);
    wi = 0; oi = 0; cyc = 0; stall_left = 0; seen_first = 0;
    while (oi < n && cyc < BUDGET) begin
      in_valid  = (wi < n) && ($urandom_range(0, 99) < in_pct);
      in_a      = (wi < n) ? a_w[wi] : $urandom;
      in_b      = (wi < n) ? b_w[wi] : $urandom;
      if (stall_n > 0 && (!seen_first || stall_left > 0)) out_ready = 1'b0;
      else out_ready = ($urandom_range(0, 99) < out_pct);
      if (stall_left > 0) stall_left--;
      @(negedge clk);
      if (out_valid) begin
        if (!seen_first) begin
          seen_first = 1;
          stall_left = stall_n - 1;
        end
        check("out_sum", out_sum, exp_w[oi]);
        check("out_last", out_last, (oi == n - 1));
        check("no_dup", (oi < wi), 1);
        if (!out_ready) check("in_ready_stall", in_ready, 0);
      end
      check("done_early", done, 0);
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      @(posedge clk); #1;
      if (in_fire)  wi++;
      if (out_fire) oi++;
      start = mid_start && (cyc == 1);
      len   = start ? LEN_W'(3) : '0;
      cyc++;
    end
    start = 1'b0; len = '0;
    in_valid = 1'b0;
    check("timeout", (cyc < BUDGET), 1);
    check("words_in", wi, n);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("carry_out", carry_out, exp_c);
    check("busy_end", busy, 0);
    check("out_valid_end", out_valid, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("carry_out_hold", carry_out, exp_c);
    @(posedge clk); #1;
  endtask

  task automatic set_words(input int n);
    for (int i = 0; i < n; i++) begin
      a_w[i] = $urandom;
      b_w[i] = $urandom;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_last", out_last, 0);
    check("rst_carry_out", carry_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single word.
    a_w[0] = 32'h0000_0005; b_w[0] = 32'h0000_0003;
    run_op(1, 1'b0, 1'b0, 100, 100, 0, 0);

    // Carry chaining, then carry escaping the top word.
    a_w[0] = 32'hFFFF_FFFF; a_w[1] = 32'h0000_0001;
    b_w[0] = 32'h0000_0001; b_w[1] = 32'h0000_0002;
    run_op(2, 1'b0, 1'b0, 100, 100, 0, 0);
    a_w[1] = 32'hFFFF_FFFF; b_w[1] = 32'h0000_0000;
    run_op(2, 1'b0, 1'b0, 100, 100, 0, 0);

    // Backpressure: output stalled four cycles after the first result.
    set_words(3);
    run_op(3, 1'b1, 1'b0, 100, 100, 4, 0);

    // start with len=0 is ignored.
    start = 1'b1; len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("len0_busy", busy, 0);
    check("len0_in_ready", in_ready, 0);
    @(posedge clk); #1;

    // start mid-RUN is ignored: word count stays at the original length.
    set_words(5);
    run_op(5, 1'b0, 1'b0, 100, 100, 0, 1);

    // Reset after one of four words.
    set_words(4);
    start = 1'b1; len = 4'd4; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cin = 1'b0;
    in_valid = 1'b1; in_a = a_w[0]; in_b = b_w[0]; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_sum", out_sum, 0);
    check("abort_out_last", out_last, 0);
    check("abort_carry_out", carry_out, 0);
    check("abort_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_done", done, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    set_words(1);
    run_op(1, 1'b1, 1'b0, 100, 100, 0, 0);

    // Maximum length.
    set_words(15);
    run_op(15, 1'b1, 1'b0, 70, 70, 0, 0);

`ifdef MULTIWORD_ADD_SUB_EN
    a_w[0] = 32'h0000_0005; b_w[0] = 32'h0000_0007;
    run_op(1, 1'b0, 1'b1, 100, 100, 0, 0);
    a_w[0] = 32'h0000_0007; b_w[0] = 32'h0000_0005;
    run_op(1, 1'b0, 1'b1, 100, 100, 0, 0);
`endif

    // Randomized operations with random flow control on both sides.
    for (int k = 0; k < 25; k++) begin
      int   n;
      logic s;
      n = $urandom_range(1, 15);
      set_words(n);
`ifdef MULTIWORD_ADD_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      run_op(n, 1'($urandom_range(0, 1)), s, $urandom_range(30, 100),
             $urandom_range(30, 100), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
